// File: rtl/game_ctrl_if.sv
// game_ctrl_if: control pulses from the scoreboard panel into game_ctrl and
// the status it reports back (state, period, timeouts, timer control, horn).
//   master: drives start_stop_i, next_i, tmo_i, time_zero_i; reads status
//   slave : game_ctrl side
`timescale 1ns/1ps
interface game_ctrl_if;
  logic       start_stop_i;
  logic       next_i;
  logic       tmo_i;
  logic       time_zero_i;
  logic       tm_load_o;
  logic       tm_run_o;
  logic [1:0] period_o;
  logic [1:0] tmo_used_o;
  logic [5:0] tmo_left_o;
  logic [2:0] state_o;
  logic       buzzer_o;
  logic       game_over_o;

  modport master (
    output start_stop_i, next_i, tmo_i, time_zero_i,
    input  tm_load_o, tm_run_o, period_o, tmo_used_o, tmo_left_o,
           state_o, buzzer_o, game_over_o
  );

  modport slave (
    input  start_stop_i, next_i, tmo_i, time_zero_i,
    output tm_load_o, tm_run_o, period_o, tmo_used_o, tmo_left_o,
           state_o, buzzer_o, game_over_o
  );
endinterface

// File: rtl/game_ctrl.sv
// game_ctrl: game flow controller -- periods, pause/resume, timeouts with a
// seconds countdown, breaks between periods and the horn.
//   clk_gc : clock, all state changes on rising edge
//   rst_gc : synchronous active-high reset
//   bus    : game_ctrl_if.slave (panel pulses in, status/timer control out)
// Every output comes straight from a flop loaded with the next-state value,
// so outputs track the current state without an extra cycle of lag.
`timescale 1ns/1ps
module game_ctrl #(
  parameter int unsigned ONE_SEC     = 25000000,
  parameter int unsigned TIMEOUT_SEC = 30,
  parameter int unsigned BUZZ_CYC    = 12500000,
  parameter int unsigned NUM_PERIODS = 4,
  parameter int unsigned TMO_MAX     = 2
) (
  input  logic         clk_gc,
  input  logic         rst_gc,
  game_ctrl_if.slave   bus
);

  localparam int unsigned PRE_W = (ONE_SEC > 1) ? $clog2(ONE_SEC) : 1;
  localparam int unsigned BUZ_W = $clog2(BUZZ_CYC + 1);

  localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(ONE_SEC - 1);
  localparam logic [BUZ_W-1:0] BUZ_LOAD    = BUZ_W'(BUZZ_CYC);
  localparam logic [1:0]       LAST_PERIOD = 2'(NUM_PERIODS - 1);
  localparam logic [1:0]       TMO_LIMIT   = 2'(TMO_MAX);
  localparam logic [5:0]       TMO_LOAD    = 6'(TIMEOUT_SEC);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_TMO   = 3'd4,
    S_BREAK = 3'd5,
    S_OVER  = 3'd6
  } state_t;

  state_t           state_q, state_n;
  logic [PRE_W-1:0] pre_q, pre_n;
  logic [BUZ_W-1:0] buz_q, buz_n;
  logic [1:0]       period_q, period_n;
  logic [1:0]       used_q, used_n;
  logic [5:0]       left_q, left_n;
  logic             buz_start;
  logic             tmo_ok;
  logic             tm_load_q, tm_run_q, buzzer_q, game_over_q;

  // A timeout request is honoured only while the period allowance lasts
  assign tmo_ok = bus.tmo_i && (used_q < TMO_LIMIT);

  // Next-state, counter and horn-trigger logic
  always_comb begin
    state_n   = state_q;
    pre_n     = pre_q;
    period_n  = period_q;
    used_n    = used_q;
    left_n    = left_q;
    buz_n     = buz_q;
    buz_start = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start_stop_i) state_n = S_LOAD;
      end
      S_LOAD: begin
        state_n = S_RUN;
      end
      S_RUN: begin
        if (bus.time_zero_i) begin
          state_n   = (period_q < LAST_PERIOD) ? S_BREAK : S_OVER;
          buz_start = 1'b1;
        end else if (bus.start_stop_i) begin
          state_n = S_PAUSE;
        end else if (tmo_ok) begin
          state_n = S_TMO;
          used_n  = used_q + 2'd1;
          left_n  = TMO_LOAD;
          pre_n   = '0;
        end
      end
      S_PAUSE: begin
        if (bus.start_stop_i) begin
          state_n = S_RUN;
        end else if (tmo_ok) begin
          state_n = S_TMO;
          used_n  = used_q + 2'd1;
          left_n  = TMO_LOAD;
          pre_n   = '0;
        end
      end
      S_TMO: begin
        // Cancel wins over a coinciding expiry, so no horn in that case
        if (bus.next_i) begin
          state_n = S_PAUSE;
          left_n  = '0;
        end else if (pre_q == PRE_LAST) begin
          pre_n  = '0;
          left_n = left_q - 6'd1;
          if (left_q == 6'd1) begin
            state_n   = S_PAUSE;
            buz_start = 1'b1;
          end
        end else begin
          pre_n = pre_q + PRE_W'(1);
        end
      end
      S_BREAK: begin
        if (bus.next_i) begin
          period_n = period_q + 2'd1;
          used_n   = '0;
          state_n  = S_LOAD;
        end
      end
      S_OVER: begin
        state_n = S_OVER;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Horn length counter; a new trigger restarts the full length
    if (buz_start) begin
      buz_n = BUZ_LOAD;
    end else if (buz_q != '0) begin
      buz_n = buz_q - BUZ_W'(1);
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_gc) begin
    if (rst_gc) begin
      state_q     <= S_IDLE;
      pre_q       <= '0;
      buz_q       <= '0;
      period_q    <= '0;
      used_q      <= '0;
      left_q      <= '0;
      tm_load_q   <= 1'b0;
      tm_run_q    <= 1'b0;
      buzzer_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      pre_q       <= pre_n;
      buz_q       <= buz_n;
      period_q    <= period_n;
      used_q      <= used_n;
      left_q      <= left_n;
      tm_load_q   <= (state_n == S_LOAD);
      tm_run_q    <= (state_n == S_RUN);
      buzzer_q    <= (buz_n != '0);
      game_over_q <= (state_n == S_OVER);
    end
  end

  assign bus.state_o     = state_q;
  assign bus.tm_load_o   = tm_load_q;
  assign bus.tm_run_o    = tm_run_q;
  assign bus.period_o    = period_q;
  assign bus.tmo_used_o  = used_q;
  assign bus.tmo_left_o  = left_q;
  assign bus.buzzer_o    = buzzer_q;
  assign bus.game_over_o = game_over_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: self-checking bench for game_ctrl with small parameters.
// Vector table, directed multi-cycle sequences, then random stimulus against
// a reference model that tracks elapsed timeout time and horn end time.
`timescale 1ns/1ps
module tb_game_ctrl;
  localparam int ONE_SEC     = 4;
  localparam int TIMEOUT_SEC = 3;
  localparam int BUZZ_CYC    = 5;
  localparam int NUM_PERIODS = 2;
  localparam int TMO_MAX     = 1;

  logic clk_gc = 1'b0;
  logic rst_gc = 1'b0;

  game_ctrl_if bus();

  game_ctrl #(
    .ONE_SEC(ONE_SEC), .TIMEOUT_SEC(TIMEOUT_SEC), .BUZZ_CYC(BUZZ_CYC),
    .NUM_PERIODS(NUM_PERIODS), .TMO_MAX(TMO_MAX)
  ) dut (
    .clk_gc(clk_gc),
    .rst_gc(rst_gc),
    .bus(bus)
  );

  always #5 clk_gc = ~clk_gc;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: state code, period, timeouts used, cycles spent in the
  // current timeout, cycle counter and last cycle the horn is high.
  int m_st, m_per, m_used, m_tcyc, m_cyc, m_buzz_last;

  typedef struct {
    bit r, ss, nx, tm, tz;
    logic [16:0] exp;
  } vec_t;

  function automatic logic [16:0] ov(input int st, ld, run, per, used, left, buz, ovr);
    return {3'(st), 1'(ld), 1'(run), 2'(per), 2'(used), 6'(left), 1'(buz), 1'(ovr)};
  endfunction

  function automatic vec_t mk(input bit r, ss, nx, tm, tz,
                              input int st, ld, run, per, used, left, buz, ovr);
    vec_t v;
    v.r = r; v.ss = ss; v.nx = nx; v.tm = tm; v.tz = tz;
    v.exp = ov(st, ld, run, per, used, left, buz, ovr);
    return v;
  endfunction

  function automatic logic [16:0] dut_vec();
    return {bus.state_o, bus.tm_load_o, bus.tm_run_o, bus.period_o, bus.tmo_used_o,
            bus.tmo_left_o, bus.buzzer_o, bus.game_over_o};
  endfunction

  function automatic logic [16:0] model_vec();
    int left;
    left = (m_st == 4) ? (TIMEOUT_SEC - m_tcyc / ONE_SEC) : 0;
    return ov(m_st, int'(m_st == 1), int'(m_st == 2), m_per, m_used, left,
              int'(m_cyc <= m_buzz_last), int'(m_st == 6));
  endfunction

  task automatic model_step(input bit r, ss, nx, tm, tz);
    bit buzz_ev;
    buzz_ev = 1'b0;
    if (r) begin
      m_st = 0; m_per = 0; m_used = 0; m_tcyc = 0; m_cyc = 0; m_buzz_last = -1;
      return;
    end
    case (m_st)
      0: if (ss) m_st = 1;
      1: m_st = 2;
      2, 3: begin
        if (m_st == 2 && tz) begin
          m_st = (m_per < NUM_PERIODS - 1) ? 5 : 6;
          buzz_ev = 1'b1;
        end else if (ss) begin
          m_st = (m_st == 2) ? 3 : 2;
        end else if (tm && m_used < TMO_MAX) begin
          m_st = 4; m_used++; m_tcyc = 0;
        end
      end
      4: begin
        if (nx) m_st = 3;
        else begin
          m_tcyc++;
          if (TIMEOUT_SEC - m_tcyc / ONE_SEC == 0) begin
            m_st = 3; buzz_ev = 1'b1;
          end
        end
      end
      5: if (nx) begin m_per++; m_used = 0; m_st = 1; end
      default: ;
    endcase
    if (buzz_ev) m_buzz_last = m_cyc + BUZZ_CYC;
    m_cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model, settle past the edge
  task automatic drive(input bit r, ss, nx, tm, tz);
    rst_gc           = r;
    bus.start_stop_i = ss;
    bus.next_i       = nx;
    bus.tmo_i        = tm;
    bus.time_zero_i  = tz;
    @(posedge clk_gc);
    #1;
    model_step(r, ss, nx, tm, tz);
  endtask

  task automatic step_chk(input string name, input bit r, ss, nx, tm, tz);
    drive(r, ss, nx, tm, tz);
    check(name, 32'(dut_vec()), 32'(model_vec()));
  endtask

  vec_t vecs[18];
  bit rr, rss, rnx, rtm, rtz;
  int over_run;

  initial begin
    rst_gc = 1'b0;
    bus.start_stop_i = 1'b0; bus.next_i = 1'b0; bus.tmo_i = 1'b0; bus.time_zero_i = 1'b0;
    m_st = 0; m_per = 0; m_used = 0; m_tcyc = 0; m_cyc = 0; m_buzz_last = -1;

    //            r ss nx tm tz   st ld run per used left buz ovr
    vecs[0]  = mk(1, 0, 0, 0, 0,  0, 0, 0,  0,  0,   0,   0,  0);
    vecs[1]  = mk(0, 0, 0, 0, 0,  0, 0, 0,  0,  0,   0,   0,  0);
    vecs[2]  = mk(0, 0, 1, 1, 1,  0, 0, 0,  0,  0,   0,   0,  0);
    vecs[3]  = mk(0, 1, 0, 0, 0,  1, 1, 0,  0,  0,   0,   0,  0);
    vecs[4]  = mk(0, 0, 0, 0, 0,  2, 0, 1,  0,  0,   0,   0,  0);
    vecs[5]  = mk(0, 1, 0, 1, 1,  5, 0, 0,  0,  0,   0,   1,  0);
    vecs[6]  = mk(0, 1, 0, 1, 0,  5, 0, 0,  0,  0,   0,   1,  0);
    vecs[7]  = mk(0, 0, 0, 0, 0,  5, 0, 0,  0,  0,   0,   1,  0);
    vecs[8]  = mk(0, 0, 1, 0, 0,  1, 1, 0,  1,  0,   0,   1,  0);
    vecs[9]  = mk(0, 0, 0, 0, 0,  2, 0, 1,  1,  0,   0,   1,  0);
    vecs[10] = mk(0, 0, 0, 0, 0,  2, 0, 1,  1,  0,   0,   0,  0);
    vecs[11] = mk(0, 0, 0, 1, 0,  4, 0, 0,  1,  1,   3,   0,  0);
    vecs[12] = mk(0, 0, 1, 0, 0,  3, 0, 0,  1,  1,   0,   0,  0);
    vecs[13] = mk(0, 0, 0, 1, 0,  3, 0, 0,  1,  1,   0,   0,  0);
    vecs[14] = mk(0, 1, 0, 0, 0,  2, 0, 1,  1,  1,   0,   0,  0);
    vecs[15] = mk(0, 0, 0, 0, 1,  6, 0, 0,  1,  1,   0,   1,  1);
    vecs[16] = mk(0, 1, 1, 1, 1,  6, 0, 0,  1,  1,   0,   1,  1);
    vecs[17] = mk(1, 0, 0, 0, 0,  0, 0, 0,  0,  0,   0,   0,  0);

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].r, vecs[i].ss, vecs[i].nx, vecs[i].tm, vecs[i].tz);
      check($sformatf("vec%0d", i), 32'(dut_vec()), 32'(vecs[i].exp));
    end

    // Timeout runs to expiry, horn length, allowance exhausted
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    step_chk("tmo_enter", 0, 0, 0, 1, 0);
    check("tmo_left_load", 32'(bus.tmo_left_o), 32'd3);
    for (int k = 1; k <= 12; k++) begin
      step_chk("tmo_count", 0, 0, 0, 0, 0);
      if (k < 12) begin
        check("tmo_left", 32'(bus.tmo_left_o), 32'(3 - k / 4));
        check("tmo_state", 32'(bus.state_o), 32'd4);
      end
    end
    check("tmo_expire_state", 32'(bus.state_o), 32'd3);
    check("tmo_expire_left", 32'(bus.tmo_left_o), 32'd0);
    check("tmo_expire_buz", 32'(bus.buzzer_o), 32'd1);
    for (int j = 0; j < 4; j++) begin
      drive(0, 0, 0, 0, 0);
      check("buz_high", 32'(bus.buzzer_o), 32'd1);
    end
    drive(0, 0, 0, 0, 0);
    check("buz_low", 32'(bus.buzzer_o), 32'd0);
    step_chk("tmo_denied_pause", 0, 0, 0, 1, 0);
    check("tmo_denied_pause_st", 32'(bus.state_o), 32'd3);
    step_chk("resume", 0, 1, 0, 0, 0);
    step_chk("tmo_denied_run", 0, 0, 0, 1, 0);
    check("tmo_denied_run_st", 32'(bus.state_o), 32'd2);

    // Timeout cancelled at two seconds left, resume without reload
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) drive(0, 0, 0, 0, 0);
    check("cancel_pre_left", 32'(bus.tmo_left_o), 32'd2);
    step_chk("cancel", 0, 0, 1, 0, 0);
    check("cancel_vec", 32'(dut_vec()), 32'(ov(3, 0, 0, 0, 1, 0, 0, 0)));
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0);
      check("cancel_no_buz", 32'(bus.buzzer_o), 32'd0);
    end
    drive(0, 1, 0, 0, 0);
    check("resume_no_load", 32'(dut_vec()), 32'(ov(2, 0, 1, 0, 1, 0, 0, 0)));

    // Reset during a timeout with the horn still sounding
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    step_chk("tmo_with_buz", 0, 0, 0, 1, 0);
    check("tmo_with_buz_st", 32'(bus.state_o), 32'd4);
    check("tmo_with_buz_b", 32'(bus.buzzer_o), 32'd1);
    drive(1, 1, 1, 1, 1);
    check("mid_reset", 32'(dut_vec()), 32'd0);

    // Random stimulus against the reference model
    drive(1, 0, 0, 0, 0);
    over_run = 0;
    for (int c = 0; c < 3000; c++) begin
      rr  = ($urandom_range(0, 299) == 0) || (over_run > 15);
      rss = ($urandom_range(0, 5) == 0);
      rnx = ($urandom_range(0, 9) == 0);
      rtm = ($urandom_range(0, 5) == 0);
      rtz = ($urandom_range(0, 29) == 0);
      step_chk("rand", rr, rss, rnx, rtm, rtz);
      over_run = (m_st == 6) ? over_run + 1 : 0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
